// File: rtl/fpu_divsqrt_ctl_if.sv
// Bundle of decode, datapath and writeback signals around the FP32
// divide/square-root controller. The master side is the surrounding pipe
// (decode, datapath, writeback arbiter); the slave side is the controller.
interface fpu_divsqrt_ctl_if;
  // decode side
  logic        dec_fpu_valid;
  logic        dec_fpu_div;
  logic        dec_fpu_sqrt;
  logic [2:0]  dec_fpu_rm;
  logic [4:0]  dec_fpu_rd;
  logic        divsqrt_ready;
  logic        divsqrt_busy;
  logic        dec_tlu_flush;
  // datapath side
  logic        dp_start;
  logic        dp_sqrt;
  logic [2:0]  dp_rm;
  logic        dp_kill;
  logic        dp_early_done;
  logic [31:0] dp_result;
  logic [4:0]  dp_fflags;
  // writeback side
  logic        fpu_wb_valid;
  logic [4:0]  fpu_wb_rd;
  logic [31:0] fpu_wb_data;
  logic [4:0]  fpu_wb_fflags;
  logic        fpu_wb_ready;

  modport master (
    output dec_fpu_valid, dec_fpu_div, dec_fpu_sqrt, dec_fpu_rm, dec_fpu_rd,
    output dec_tlu_flush, dp_early_done, dp_result, dp_fflags, fpu_wb_ready,
    input  divsqrt_ready, divsqrt_busy, dp_start, dp_sqrt, dp_rm, dp_kill,
    input  fpu_wb_valid, fpu_wb_rd, fpu_wb_data, fpu_wb_fflags
  );

  modport slave (
    input  dec_fpu_valid, dec_fpu_div, dec_fpu_sqrt, dec_fpu_rm, dec_fpu_rd,
    input  dec_tlu_flush, dp_early_done, dp_result, dp_fflags, fpu_wb_ready,
    output divsqrt_ready, divsqrt_busy, dp_start, dp_sqrt, dp_rm, dp_kill,
    output fpu_wb_valid, fpu_wb_rd, fpu_wb_data, fpu_wb_fflags
  );
endinterface

// File: rtl/fpu_divsqrt_ctl.sv
// Sequencer for the shared iterative FP32 div/sqrt datapath: accepts one op
// from decode, counts datapath iterations (or stops early on special
// operands), holds the result until the writeback port is granted, and
// abandons in-flight work on a pipeline flush.
module fpu_divsqrt_ctl #(
  parameter int DIV_CYCLES  = 14,
  parameter int SQRT_CYCLES = 16,
  parameter int CNT_W       = 5
) (
  input logic               clk,
  input logic               rst,
  fpu_divsqrt_ctl_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter load values: the last iteration is the one where cnt reads 0.
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_CYCLES - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             op_sqrt;
  logic [2:0]       rm;
  logic [4:0]       rd;
  logic [31:0]      result;
  logic [4:0]       fflags;

  logic ready;
  logic accept;
  logic wb_valid;
  logic handshake;

  // Handshake decode; a flush blocks acceptance and masks writeback.
  always_comb begin
    ready     = (state == S_IDLE) & ~bus.dec_tlu_flush;
    accept    = bus.dec_fpu_valid & ready & (bus.dec_fpu_div ^ bus.dec_fpu_sqrt);
    wb_valid  = (state == S_DONE) & ~bus.dec_tlu_flush;
    handshake = wb_valid & bus.fpu_wb_ready;
  end

  assign bus.divsqrt_ready = ready;
  assign bus.divsqrt_busy  = (state != S_IDLE);
  assign bus.dp_start      = accept;
  // Op and rounding mode come straight from decode in the accept cycle so the
  // datapath sees them together with the start pulse, then from the latch.
  assign bus.dp_sqrt       = accept ? bus.dec_fpu_sqrt : op_sqrt;
  assign bus.dp_rm         = accept ? bus.dec_fpu_rm   : rm;
  assign bus.dp_kill       = (state == S_BUSY) & bus.dec_tlu_flush;
  assign bus.fpu_wb_valid  = wb_valid;
  assign bus.fpu_wb_rd     = wb_valid ? rd     : 5'd0;
  assign bus.fpu_wb_data   = wb_valid ? result : 32'd0;
  assign bus.fpu_wb_fflags = wb_valid ? fflags : 5'd0;

  // Control FSM with iteration counter and op/result latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_sqrt <= 1'b0;
      rm      <= 3'd0;
      rd      <= 5'd0;
      result  <= 32'd0;
      fflags  <= 5'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_sqrt <= bus.dec_fpu_sqrt;
            rm      <= bus.dec_fpu_rm;
            rd      <= bus.dec_fpu_rd;
            cnt     <= bus.dec_fpu_sqrt ? SQRT_LOAD : DIV_LOAD;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Flush takes priority over a completion in the same cycle.
          if (bus.dec_tlu_flush) begin
            state <= S_IDLE;
          end else if ((cnt == '0) || bus.dp_early_done) begin
            result <= bus.dp_result;
            fflags <= bus.dp_fflags;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.dec_tlu_flush || handshake) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_divsqrt_ctl.sv
// Directed bench for fpu_divsqrt_ctl. Inputs change just after the falling
// edge; outputs are sampled 1 time unit later, well before the rising edge.
// Cycle T is the cycle in which an op is presented and accepted.
module tb_fpu_divsqrt_ctl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpu_divsqrt_ctl_if bus ();

  fpu_divsqrt_ctl #(
    .DIV_CYCLES (14),
    .SQRT_CYCLES(16),
    .CNT_W      (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.dec_fpu_valid = 1'b0;
    bus.dec_fpu_div   = 1'b0;
    bus.dec_fpu_sqrt  = 1'b0;
    bus.dec_fpu_rm    = 3'd0;
    bus.dec_fpu_rd    = 5'd0;
    bus.dec_tlu_flush = 1'b0;
    bus.dp_early_done = 1'b0;
    bus.dp_result     = 32'd0;
    bus.dp_fflags     = 5'd0;
    bus.fpu_wb_ready  = 1'b0;
  endtask

  task automatic present(input logic div, input logic sqrt, input logic [4:0] rd,
                         input logic [2:0] rm);
    bus.dec_fpu_valid = 1'b1;
    bus.dec_fpu_div   = div;
    bus.dec_fpu_sqrt  = sqrt;
    bus.dec_fpu_rd    = rd;
    bus.dec_fpu_rm    = rm;
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    next(); next();
    #1;
    chk("rst_ready",  32'(bus.divsqrt_ready), 32'd1);
    chk("rst_busy",   32'(bus.divsqrt_busy),  32'd0);
    chk("rst_start",  32'(bus.dp_start),      32'd0);
    chk("rst_kill",   32'(bus.dp_kill),       32'd0);
    chk("rst_wbv",    32'(bus.fpu_wb_valid),  32'd0);
    chk("rst_sqrt",   32'(bus.dp_sqrt),       32'd0);
    chk("rst_rm",     32'(bus.dp_rm),         32'd0);
    rst = 1'b0;
    next();

    // fdiv rd=5 rm=1, normal latency 14
    present(1'b1, 1'b0, 5'd5, 3'b001);
    #1;
    chk("div_start_T", 32'(bus.dp_start), 32'd1);
    chk("div_sqrt_T",  32'(bus.dp_sqrt),  32'd0);
    chk("div_rm_T",    32'(bus.dp_rm),    32'd1);
    next(); clear_inputs(); #1;                       // T+1
    chk("div_busy_T1",  32'(bus.divsqrt_busy),  32'd1);
    chk("div_ready_T1", 32'(bus.divsqrt_ready), 32'd0);
    chk("div_rm_held",  32'(bus.dp_rm),         32'd1);
    for (int k = 1; k < 14; k++) begin
      chk("div_wait_wbv",   32'(bus.fpu_wb_valid), 32'd0);
      chk("div_wait_start", 32'(bus.dp_start),     32'd0);
      next(); #1;
    end                                               // T+14
    bus.dp_result = 32'h3F80_0000; bus.dp_fflags = 5'd0; #1;
    chk("div_T14_wbv", 32'(bus.fpu_wb_valid), 32'd0);
    next();                                           // T+15
    bus.dp_result = 32'hDEAD_BEEF; bus.dp_fflags = 5'b11111; #1;
    chk("div_T15_wbv",  32'(bus.fpu_wb_valid), 32'd1);
    chk("div_T15_rd",   32'(bus.fpu_wb_rd),    32'd5);
    chk("div_T15_data", bus.fpu_wb_data,       32'h3F80_0000);
    chk("div_T15_ff",   32'(bus.fpu_wb_fflags), 32'd0);
    bus.fpu_wb_ready = 1'b1;
    next(); clear_inputs(); #1;                       // T+16
    chk("div_T16_ready", 32'(bus.divsqrt_ready), 32'd1);
    chk("div_T16_wbv",   32'(bus.fpu_wb_valid),  32'd0);
    chk("div_T16_data",  bus.fpu_wb_data,        32'd0);

    // fsqrt rd=7 rm=2, latency 16; decode retries while busy are ignored
    present(1'b0, 1'b1, 5'd7, 3'b010);
    #1;
    chk("sqrt_start_T", 32'(bus.dp_start), 32'd1);
    chk("sqrt_sqrt_T",  32'(bus.dp_sqrt),  32'd1);
    next(); clear_inputs();                           // T+1
    present(1'b1, 1'b0, 5'd9, 3'b111);
    #1;
    for (int k = 1; k < 16; k++) begin
      chk("sqrt_wait_start", 32'(bus.dp_start),     32'd0);
      chk("sqrt_wait_sqrt",  32'(bus.dp_sqrt),      32'd1);
      chk("sqrt_wait_rm",    32'(bus.dp_rm),        32'd2);
      chk("sqrt_wait_wbv",   32'(bus.fpu_wb_valid), 32'd0);
      next(); #1;
    end                                               // T+16
    clear_inputs();
    bus.dp_result = 32'h4000_0000; bus.dp_fflags = 5'b00001; #1;
    chk("sqrt_T16_wbv", 32'(bus.fpu_wb_valid), 32'd0);
    next();                                           // T+17
    bus.dp_result = 32'h1234_5678; bus.dp_fflags = 5'b10000;
    // DONE held 5 cycles without grant
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_wbv",  32'(bus.fpu_wb_valid),  32'd1);
      chk("hold_rd",   32'(bus.fpu_wb_rd),     32'd7);
      chk("hold_data", bus.fpu_wb_data,        32'h4000_0000);
      chk("hold_ff",   32'(bus.fpu_wb_fflags), 32'd1);
      next();
    end
    bus.fpu_wb_ready = 1'b1; #1;
    chk("hold_6th_wbv", 32'(bus.fpu_wb_valid), 32'd1);
    next(); clear_inputs(); #1;
    chk("hold_after_busy",  32'(bus.divsqrt_busy),  32'd0);
    chk("hold_after_ready", 32'(bus.divsqrt_ready), 32'd1);

    // fdiv rd=9 with early done at T+2
    present(1'b1, 1'b0, 5'd9, 3'b000);
    #1;
    chk("early_start_T", 32'(bus.dp_start), 32'd1);
    next(); clear_inputs(); #1;                       // T+1
    chk("early_T1_wbv", 32'(bus.fpu_wb_valid), 32'd0);
    next();                                           // T+2
    bus.dp_early_done = 1'b1; bus.dp_result = 32'h7F80_0000; bus.dp_fflags = 5'b01000; #1;
    chk("early_T2_wbv", 32'(bus.fpu_wb_valid), 32'd0);
    next(); clear_inputs(); #1;                       // T+3
    chk("early_T3_wbv",  32'(bus.fpu_wb_valid),  32'd1);
    chk("early_T3_rd",   32'(bus.fpu_wb_rd),     32'd9);
    chk("early_T3_data", bus.fpu_wb_data,        32'h7F80_0000);
    chk("early_T3_ff",   32'(bus.fpu_wb_fflags), 32'h08);
    bus.fpu_wb_ready = 1'b1;
    next(); clear_inputs();                           // T+4, IDLE
    bus.dp_early_done = 1'b1; #1;
    chk("early_idle_ready", 32'(bus.divsqrt_ready), 32'd1);
    next(); clear_inputs(); #1;
    chk("early_idle_ign_busy", 32'(bus.divsqrt_busy), 32'd0);
    chk("early_idle_ign_wbv",  32'(bus.fpu_wb_valid), 32'd0);

    // fdiv rd=3 flushed at T+6, then fsqrt rd=4 accepted at T+7
    present(1'b1, 1'b0, 5'd3, 3'b000);
    next(); clear_inputs();                           // T+1
    for (int k = 1; k < 6; k++) begin
      #1;
      chk("flush_pre_kill", 32'(bus.dp_kill), 32'd0);
      next();
    end                                               // T+6
    bus.dec_tlu_flush = 1'b1; #1;
    chk("flush_T6_kill",  32'(bus.dp_kill),       32'd1);
    chk("flush_T6_ready", 32'(bus.divsqrt_ready), 32'd0);
    next(); clear_inputs(); #1;                       // T+7
    chk("flush_T7_busy",  32'(bus.divsqrt_busy),  32'd0);
    chk("flush_T7_kill",  32'(bus.dp_kill),       32'd0);
    chk("flush_T7_ready", 32'(bus.divsqrt_ready), 32'd1);
    present(1'b0, 1'b1, 5'd4, 3'b011); #1;
    chk("flush_T7_start", 32'(bus.dp_start), 32'd1);
    chk("flush_T7_sqrt",  32'(bus.dp_sqrt),  32'd1);
    next(); clear_inputs(); #1;                       // U+1
    for (int k = 1; k < 16; k++) begin
      chk("flush_new_wbv", 32'(bus.fpu_wb_valid), 32'd0);
      next(); #1;
    end                                               // U+16
    bus.dp_result = 32'h3FB5_04F3; bus.dp_fflags = 5'b00001;
    next(); clear_inputs(); #1;                       // U+17, DONE
    chk("flush_new_wbv_U17", 32'(bus.fpu_wb_valid), 32'd1);
    chk("flush_new_rd_U17",  32'(bus.fpu_wb_rd),    32'd4);
    chk("flush_new_data",    bus.fpu_wb_data,       32'h3FB5_04F3);

    // flush in DONE with grant: no writeback, no kill
    bus.dec_tlu_flush = 1'b1; bus.fpu_wb_ready = 1'b1; #1;
    chk("dflush_wbv",  32'(bus.fpu_wb_valid), 32'd0);
    chk("dflush_rd",   32'(bus.fpu_wb_rd),    32'd0);
    chk("dflush_kill", 32'(bus.dp_kill),      32'd0);
    next(); clear_inputs(); #1;
    chk("dflush_busy", 32'(bus.divsqrt_busy), 32'd0);
    chk("dflush_after_wbv", 32'(bus.fpu_wb_valid), 32'd0);

    // flush coincident with accept
    present(1'b1, 1'b0, 5'd1, 3'b000); bus.dec_tlu_flush = 1'b1; #1;
    chk("faccept_start", 32'(bus.dp_start), 32'd0);
    next(); clear_inputs(); #1;
    chk("faccept_busy", 32'(bus.divsqrt_busy), 32'd0);

    // invalid ops: both bits, neither bit
    present(1'b1, 1'b1, 5'd2, 3'b000); #1;
    chk("inv_both_start", 32'(bus.dp_start), 32'd0);
    next(); clear_inputs(); #1;
    chk("inv_both_busy", 32'(bus.divsqrt_busy), 32'd0);
    present(1'b0, 1'b0, 5'd2, 3'b000); #1;
    chk("inv_none_start", 32'(bus.dp_start), 32'd0);
    next(); clear_inputs(); #1;
    chk("inv_none_busy", 32'(bus.divsqrt_busy), 32'd0);

    // reset mid-BUSY
    present(1'b0, 1'b1, 5'd6, 3'b100);
    next(); clear_inputs(); next(); next();           // T+3
    #1;
    chk("rbusy_pre_busy", 32'(bus.divsqrt_busy), 32'd1);
    chk("rbusy_pre_rm",   32'(bus.dp_rm),        32'd4);
    rst = 1'b1; #1;
    chk("rbusy_kill_T3", 32'(bus.dp_kill), 32'd0);
    next(); #1;                                       // T+4, rst still high
    chk("rbusy_busy",  32'(bus.divsqrt_busy),  32'd0);
    chk("rbusy_ready", 32'(bus.divsqrt_ready), 32'd1);
    chk("rbusy_kill",  32'(bus.dp_kill),       32'd0);
    chk("rbusy_sqrt",  32'(bus.dp_sqrt),       32'd0);
    chk("rbusy_rm",    32'(bus.dp_rm),         32'd0);
    chk("rbusy_wbv",   32'(bus.fpu_wb_valid),  32'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      next(); #1;
      chk("rbusy_no_wb", 32'(bus.fpu_wb_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
